// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Purpose:
//   Program-counter generator for an instruction fetch stage. After reset the
//   unit spends one BOOT cycle presenting RESET_PC with pc_valid low, then
//   enters RUN where each enabled cycle advances the PC to PC+4 (sequential)
//   or PC+ImmOp (taken branch) and counts the advance in retire_count.
//
// Optional feature (macro MISALIGN_TRAP_EN):
//   defined   : a computed next PC with bits [1:0] != 00 is not loaded; the
//               unit moves to HALT, raises a sticky trap and keeps the PC of
//               the branching instruction. Only reset leaves HALT.
//   undefined : bits [1:0] of the next PC are forced to 00 and the PC is
//               loaded normally; trap and halted are constant 0 and HALT is
//               never entered.
//
// Advance semantics:
//   en is a one-sided advance qualifier (no back-pressure). In RUN, a cycle
//   with en=1 consumes PCsrc/ImmOp combinationally and the new PC appears
//   after the next rising edge. en=0 stalls: PC, count and state hold and
//   PCsrc/ImmOp are ignored. In BOOT and HALT all three inputs are ignored.
//
// Ports:
//   clk          in   clock, rising-edge active
//   rst          in   asynchronous active-high reset
//   en           in   fetch advance enable (0 = stall)
//   PCsrc        in   1 selects PC+ImmOp, 0 selects PC+4
//   ImmOp        in   [WIDTH] sign-extended branch offset
//   PC           out  [WIDTH] current fetch address
//   pc_valid     out  PC is a fetchable address this cycle (RUN only)
//   halted       out  unit is in HALT
//   trap         out  sticky misaligned-target indication
//   retire_count out  [WIDTH] number of accepted PC advances (wraps)
//   dbg_state_o  out  [2] FSM state for debug/checkers (0 BOOT,1 RUN,2 HALT)
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter int unsigned          WIDTH    = 32,
  parameter logic [WIDTH-1:0]     RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             PCsrc,
  input  logic [WIDTH-1:0] ImmOp,
  output logic [WIDTH-1:0] PC,
  output logic             pc_valid,
  output logic             halted,
  output logic             trap,
  output logic [WIDTH-1:0] retire_count,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pc_target;

  // Candidate next PC; addition wraps modulo 2^WIDTH by construction.
  assign pc_target = pc_q + (PCsrc ? ImmOp : WIDTH'(4));

`ifdef MISALIGN_TRAP_EN
  logic trap_q, trap_d;
  logic misaligned;

  assign misaligned = (pc_target[1:0] != 2'b00);
`endif

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= trap_d;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
`ifdef MISALIGN_TRAP_EN
    trap_d  = trap_q;
`endif

    unique case (state_q)
      ST_BOOT: begin
        // Single presentation cycle of RESET_PC; inputs deliberately ignored.
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (en) begin
`ifdef MISALIGN_TRAP_EN
          if (misaligned) begin
            // Keep the branching instruction's PC and count for inspection.
            state_d = ST_HALT;
            trap_d  = 1'b1;
          end else begin
            pc_d  = pc_target;
            cnt_d = cnt_q + WIDTH'(1);
          end
`else
          // Low bits are dropped so fetch stays word aligned.
          pc_d  = pc_target & ~WIDTH'(3);
          cnt_d = cnt_q + WIDTH'(1);
`endif
        end
      end

      ST_HALT: begin
        // Terminal until reset.
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign PC           = pc_q;
  assign retire_count = cnt_q;
  assign pc_valid     = (state_q == ST_RUN);
  assign dbg_state_o  = state_q;

`ifdef MISALIGN_TRAP_EN
  assign halted = (state_q == ST_HALT);
  assign trap   = trap_q;
`else
  assign halted = 1'b0;
  assign trap   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Bench for pc_fetch_unit (WIDTH=32, RESET_PC=0). Inputs are driven one time
// unit after each rising edge and outputs are sampled at the same point, i.e.
// the value reflects the edge just taken.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pc_fetch_unit;

  localparam int unsigned W = 32;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic         clk;
  logic         rst;
  logic         en;
  logic         pcsrc;
  logic [W-1:0] imm;
  logic [W-1:0] pc;
  logic         pc_valid;
  logic         halted;
  logic         trap;
  logic [W-1:0] retire_count;
  logic [1:0]   dbg_state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  pc_fetch_unit #(
    .WIDTH    (W),
    .RESET_PC (32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .PCsrc        (pcsrc),
    .ImmOp        (imm),
    .PC           (pc),
    .pc_valid     (pc_valid),
    .halted       (halted),
    .trap         (trap),
    .retire_count (retire_count),
    .dbg_state_o  (dbg_state)
  );

  // -------------------------------------------------------------------------
  // Scoreboard counters and comparison helper
  // -------------------------------------------------------------------------
  int n_checks;
  int n_fail;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] e_pc, input logic [W-1:0] e_cnt,
                         input logic e_valid, input logic e_halt, input logic e_trap);
    chk({tag, ".pc"},     pc,                 e_pc);
    chk({tag, ".cnt"},    retire_count,       e_cnt);
    chk({tag, ".valid"},  W'(pc_valid),       W'(e_valid));
    chk({tag, ".halted"}, W'(halted),         W'(e_halt));
    chk({tag, ".trap"},   W'(trap),           W'(e_trap));
  endtask

  // -------------------------------------------------------------------------
  // Behavioural reference model: fetch address, advance count, and whether
  // the unit is still in its boot cycle or has stopped on a bad target.
  // -------------------------------------------------------------------------
  logic [W-1:0] m_pc;
  logic [W-1:0] m_cnt;
  bit           m_booting;
  bit           m_stopped;
  bit           m_trap;

  function automatic void model_reset();
    m_pc      = 32'h0;
    m_cnt     = 32'h0;
    m_booting = 1'b1;
    m_stopped = 1'b0;
    m_trap    = 1'b0;
  endfunction

  // Applies one rising edge to the model with the given inputs.
  function automatic void model_edge(input logic e, input logic s, input logic [W-1:0] i);
    longint unsigned sum;
    logic [W-1:0]    nxt;
    if (m_booting) begin
      m_booting = 1'b0;
      return;
    end
    if (m_stopped || !e) return;
    sum = longint'(m_pc) + (s ? longint'(i) : 64'd4);
    nxt = sum[W-1:0];
`ifdef MISALIGN_TRAP_EN
    if (nxt % 4 != 0) begin
      m_stopped = 1'b1;
      m_trap    = 1'b1;
      return;
    end
`endif
    m_pc  = nxt - (nxt % 4);
    m_cnt = m_cnt + 1;
  endfunction

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic s, input logic [W-1:0] i);
    en    = e;
    pcsrc = s;
    imm   = i;
  endtask

  // Holds reset for two edges, releases it just after an edge so the next
  // edge is the BOOT->RUN transition.
  task automatic reset_dut();
    rst = 1'b1;
    drive(1'b1, 1'b1, 32'h100);
    repeat (2) tick();
    chk_all("rst_hold", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    model_reset();
  endtask

  // -------------------------------------------------------------------------
  // Vector table
  // -------------------------------------------------------------------------
  typedef struct {
    logic         en;
    logic         src;
    logic [W-1:0] imm;
    logic [W-1:0] exp_pc;
    logic [W-1:0] exp_cnt;
  } vec_t;

  vec_t tbl[$];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    drive(1'b0, 1'b0, 32'h0);

    // Sequential run, backward branch, stalls, zero offset, large negative.
    tbl.push_back('{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0004, 32'd1});
    tbl.push_back('{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0008, 32'd2});
    tbl.push_back('{1'b1, 1'b0, 32'h0000_0000, 32'h0000_000C, 32'd3});
    tbl.push_back('{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0010, 32'd4});
    tbl.push_back('{1'b1, 1'b1, 32'hFFFF_FFF8, 32'h0000_0008, 32'd5});
    tbl.push_back('{1'b1, 1'b1, 32'h0000_0018, 32'h0000_0020, 32'd6});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0040, 32'h0000_0020, 32'd6});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0040, 32'h0000_0020, 32'd6});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0040, 32'h0000_0020, 32'd6});
    tbl.push_back('{1'b1, 1'b1, 32'h0000_0040, 32'h0000_0060, 32'd7});
    tbl.push_back('{1'b1, 1'b1, 32'h0000_0000, 32'h0000_0060, 32'd8});
    tbl.push_back('{1'b1, 1'b1, 32'hFFFF_FFA8, 32'h0000_0008, 32'd9});

    // --- reset and BOOT cycle --------------------------------------------
    repeat (2) tick();
    chk_all("reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    reset_dut();
    #1;
    chk_all("boot", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    // Inputs present during BOOT must not move the PC.
    drive(1'b1, 1'b1, 32'h100);
    tick();
    chk_all("boot_exit", 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // --- table ------------------------------------------------------------
    foreach (tbl[k]) begin
      drive(tbl[k].en, tbl[k].src, tbl[k].imm);
      tick();
      chk($sformatf("tbl%0d.pc", k),  pc,           tbl[k].exp_pc);
      chk($sformatf("tbl%0d.cnt", k), retire_count, tbl[k].exp_cnt);
      chk($sformatf("tbl%0d.valid", k), W'(pc_valid), 32'h1);
    end

    // --- address wrap -----------------------------------------------------
    drive(1'b1, 1'b1, 32'hFFFF_FFF4);
    tick();
    chk_all("to_top", 32'hFFFF_FFFC, 32'd10, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 32'h0);
    tick();
    chk_all("wrap", 32'h0000_0000, 32'd11, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 32'h8);
    tick();
    chk_all("to_08", 32'h0000_0008, 32'd12, 1'b1, 1'b0, 1'b0);

    // --- misaligned branch target (0x08 + 2) ------------------------------
    drive(1'b1, 1'b1, 32'h2);
    tick();
`ifdef MISALIGN_TRAP_EN
    chk_all("misalign", 32'h8, 32'd12, 1'b0, 1'b1, 1'b1);
    for (int p = 0; p < 3; p++) begin
      drive(1'b1, p[0], 32'h40);
      tick();
      chk_all("halt_hold", 32'h8, 32'd12, 1'b0, 1'b1, 1'b1);
    end
`else
    chk_all("misalign", 32'h8, 32'd13, 1'b1, 1'b0, 1'b0);
`endif

    reset_dut();
    #1;
    chk_all("reboot", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 32'h40);
    tick();
    chk_all("to_40", 32'h40, 32'd1, 1'b1, 1'b0, 1'b0);

    // --- asynchronous reset between edges ---------------------------------
    drive(1'b1, 1'b0, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("async_hold", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // --- randomized run against the model ---------------------------------
    rst = 1'b0;
    model_reset();
    for (int n = 0; n < 400; n++) begin
      logic         r_en;
      logic         r_src;
      logic [W-1:0] r_imm;
      r_en  = ($urandom_range(0, 3) != 0);
      r_src = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) r_imm = $urandom;
      else                            r_imm = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      drive(r_en, r_src, r_imm);
      model_edge(r_en, r_src, r_imm);
      exp_q.push_back(m_pc);
      tick();
      chk("rnd.pc",    pc,                   exp_q.pop_front());
      chk("rnd.cnt",   retire_count,         m_cnt);
      chk("rnd.valid", W'(pc_valid),         W'(!m_booting && !m_stopped));
      chk("rnd.halt",  W'(halted),           W'(m_stopped));
      chk("rnd.trap",  W'(trap),             W'(m_trap));
      // Occasional reset keeps the trap build from sitting in HALT forever.
      if ($urandom_range(0, 63) == 0) begin
        reset_dut();
      end
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
